debounce_entradas: RTL and testbench

- Front-end stage that conditions three raw push-button/switch lines and drives the priority encoder's e1, e2, e3 inputs.
- Per channel: 2-flop synchronizer, then a stability counter.
- Each output level changes only after the raw input has held a new level for N_ESTAVEL consecutive cycles.
- A one-cycle pulse `mudou` flags any change in the debounced vector, so downstream logic can sample the encoded s1/s0 exactly once per change.

---
 rtl/debounce_entradas_pkg.sv | 11 +
 rtl/debounce_entradas_canal.sv | 65 ++++++
 rtl/debounce_entradas.sv | 51 +++++
 tb/tb_debounce_entradas.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_entradas_pkg.sv
// Shared constants and channel FSM encoding for the three-line input debouncer.
package debounce_entradas_pkg;

  localparam int N_ESTAVEL_PADRAO = 16;

  typedef enum logic {
    ESTAVEL  = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/debounce_entradas_canal.sv
// One debounced line: 2-flop synchronizer, stability counter and commit FSM.
module debounce_canal
  import debounce_entradas_pkg::*;
#(
  parameter  int N_ESTAVEL = N_ESTAVEL_PADRAO,
  localparam int CONT_W    = $clog2(N_ESTAVEL)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic nivel,
  output logic commit
);

  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(N_ESTAVEL - 1);

  logic              sa_q;
  logic              sb_q;
  logic              nivel_q;
  estado_t           estado_q;
  logic [CONT_W-1:0] cont_q;

  // Asserted in the cycle before nivel_q flips, so the top can register it
  // and raise mudou on the very edge the level commits.
  assign commit = (estado_q == CONTANDO) && (sb_q != nivel_q) && (cont_q == CONT_MAX);
  assign nivel  = nivel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      nivel_q  <= 1'b0;
      estado_q <= ESTAVEL;
      cont_q   <= '0;
    end else begin
      sa_q <= raw;
      sb_q <= sa_q;
      case (estado_q)
        ESTAVEL: begin
          if (sb_q != nivel_q) begin
            estado_q <= CONTANDO;
            cont_q   <= CONT_W'(1);
          end
        end
        CONTANDO: begin
          if (sb_q == nivel_q) begin
            estado_q <= ESTAVEL;
            cont_q   <= '0;
          end else if (cont_q == CONT_MAX) begin
            nivel_q  <= sb_q;
            estado_q <= ESTAVEL;
            cont_q   <= '0;
          end else begin
            cont_q <= cont_q + 1'b1;
          end
        end
        default: begin
          estado_q <= ESTAVEL;
          cont_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_entradas.sv
// Debounces three raw button lines into e1..e3 and pulses mudou on every change.
module debounce_entradas
  import debounce_entradas_pkg::*;
#(
  parameter int N_ESTAVEL = N_ESTAVEL_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic b1_raw,
  input  logic b2_raw,
  input  logic b3_raw,
  output logic e1,
  output logic e2,
  output logic e3,
  output logic mudou
);

  logic [2:0] raw_vec;
  logic [2:0] nivel_vec;
  logic [2:0] commit_vec;
  logic       mudou_q;

  assign raw_vec = {b1_raw, b2_raw, b3_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_canal
      debounce_canal #(
        .N_ESTAVEL(N_ESTAVEL)
      ) u_canal (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_vec[gi]),
        .nivel  (nivel_vec[gi]),
        .commit (commit_vec[gi])
      );
    end
  endgenerate

  // Simultaneous commits collapse into a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mudou_q <= 1'b0;
    end else begin
      mudou_q <= |commit_vec;
    end
  end

  assign {e1, e2, e3} = nivel_vec;
  assign mudou        = mudou_q;

endmodule

// File: tb/tb_debounce_entradas.sv
// Scoreboard bench for debounce_entradas with N_ESTAVEL=4.
module tb_debounce_entradas;

  localparam int N = 4;

  typedef struct packed {
    logic [2:0] e;
    logic       mudou;
  } saida_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic       e1, e2, e3, mudou;

  always #5 clk = ~clk;

  debounce_entradas #(.N_ESTAVEL(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .b1_raw (raw[2]),
    .b2_raw (raw[1]),
    .b3_raw (raw[0]),
    .e1     (e1),
    .e2     (e2),
    .e3     (e3),
    .mudou  (mudou)
  );

  // Window model: a level flips once the last N synchronized samples all differ from it.
  logic [2:0] m_sa, m_sb, m_e;
  logic [2:0] m_hist [N];
  saida_t     sb_q [$];
  int         total = 0;
  int         passed = 0;

  task automatic model_clear();
    m_sa = '0; m_sb = '0; m_e = '0;
    for (int j = 0; j < N; j++) m_hist[j] = '0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic rs);
    logic [2:0] flip;
    saida_t     s;
    if (rs) begin
      model_clear();
      s.e = '0; s.mudou = 1'b0;
    end else begin
      for (int j = 0; j < N - 1; j++) m_hist[j] = m_hist[j+1];
      m_hist[N-1] = m_sb;
      flip = '1;
      for (int j = 0; j < N; j++) flip &= (m_hist[j] ^ m_e);
      m_e = m_e ^ flip;
      s.e = m_e; s.mudou = |flip;
      m_sb = m_sa; m_sa = r;
    end
    sb_q.push_back(s);
  endtask

  task automatic step(input logic [2:0] r);
    raw = r;
    model_edge(r, rst);
    @(posedge clk); #1;
  endtask

  function automatic saida_t observa();
    saida_t o;
    o.e = {e1, e2, e3}; o.mudou = mudou;
    return o;
  endfunction

  task automatic test_reset();
    saida_t got, exp;
    int rise = 0, pulses = 0;
    rst = 1'b1; raw = 3'b111; model_clear();
    for (int k = 1; k <= 3; k++) begin
      step(3'b111);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_hold edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("reset_hold edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(3'b100);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_rise edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("reset_rise edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (got.e[2] && rise == 0) rise = k;
      pulses += int'(got.mudou);
    end
    total++;
    if (rise !== 6) $display("FAIL reset_latency: e1 rose on edge %0d, need edge 6", rise);
    else passed++;
    total++;
    if (pulses !== 1) $display("FAIL reset_pulses: %0d mudou cycles, need 1", pulses);
    else passed++;
  endtask

  task automatic test_glitch();
    saida_t got, exp;
    int pulses = 0, rise = 0;
    for (int k = 1; k <= 10; k++) begin
      step((k <= 3) ? 3'b110 : 3'b100);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL glitch3 edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("glitch3 edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      pulses += int'(got.mudou);
    end
    total++;
    if (pulses !== 0) $display("FAIL glitch3_pulses: %0d mudou cycles, need 0", pulses);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      step((k <= 4) ? 3'b110 : 3'b100);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL glitch4 edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("glitch4 edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (got.e[1] && rise == 0) rise = k;
    end
    total++;
    if (rise !== 6) $display("FAIL glitch4_latency: e2 rose on edge %0d, need edge 6", rise);
    else passed++;
  endtask

  task automatic test_release();
    saida_t got, exp;
    int fall = 0, pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(3'b000);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL release edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("release edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (!got.e[2] && fall == 0) fall = k;
      pulses += int'(got.mudou);
    end
    total++;
    if (fall !== 6 || pulses !== 1)
      $display("FAIL release_timing: fall edge %0d pulses %0d, need 6 and 1", fall, pulses);
    else passed++;
  endtask

  task automatic test_simultaneous();
    saida_t got, exp;
    int pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(3'b101);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL simult edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("simult edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (k == 5 || k == 6) begin
        total++;
        if (got.e !== ((k == 6) ? 3'b101 : 3'b000))
          $display("FAIL simult_edge%0d: e=%b", k, got.e);
        else passed++;
      end
      pulses += int'(got.mudou);
    end
    total++;
    if (pulses !== 1) $display("FAIL simult_pulses: %0d mudou cycles, need 1", pulses);
    else passed++;
  endtask

  task automatic test_bounce();
    saida_t got, exp;
    logic [2:0] seq [5];
    int rise = 0, pulses = 0;
    seq[0] = 3'b101; seq[1] = 3'b100; seq[2] = 3'b101; seq[3] = 3'b100; seq[4] = 3'b101;
    for (int k = 1; k <= 7; k++) begin
      step(3'b100);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL bounce_setup edge %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    for (int k = 1; k <= 12; k++) begin
      step((k <= 5) ? seq[k-1] : 3'b101);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL bounce edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("bounce edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (got.e[0] && rise == 0) rise = k;
      pulses += int'(got.mudou);
    end
    total++;
    if (rise !== 10 || pulses !== 1)
      $display("FAIL bounce_timing: rise edge %0d pulses %0d, need 10 and 1", rise, pulses);
    else passed++;
  endtask

  task automatic test_walk();
    saida_t got, exp;
    logic [2:0] prev;
    int pulses;
    prev = {e1, e2, e3};
    for (int c = 0; c < 8; c++) begin
      pulses = 0;
      for (int k = 1; k <= N + 3; k++) begin
        step(3'(c));
        got = observa(); exp = sb_q.pop_front(); total++;
        if (got !== exp) $display("FAIL walk code %0d edge %0d: got %b want %b", c, k, got, exp);
        else passed++;
        pulses += int'(got.mudou);
      end
      total++;
      if (got.e !== 3'(c) || pulses !== ((prev != 3'(c)) ? 1 : 0))
        $display("FAIL walk_code %0d: e=%b pulses %0d", c, got.e, pulses);
      else begin passed++; $display("walk code %0d: e=%b pulses=%0d", c, got.e, pulses); end
      prev = got.e;
    end
  endtask

  task automatic test_reset_mid();
    saida_t got, exp;
    int rise = 0, pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      step(3'b101);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL mid_setup edge %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    for (int k = 1; k <= 2; k++) begin
      step(3'b111);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL mid_count edge %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    total++;
    if ({e1, e2, e3, mudou} !== 4'b0000)
      $display("FAIL mid_async: got e=%b mudou=%b want 000/0", {e1, e2, e3}, mudou);
    else begin passed++; $display("mid_async: outputs cleared between edges"); end
    for (int k = 1; k <= 2; k++) begin
      step(3'b010);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL mid_hold edge %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(3'b010);
      got = observa(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL mid_restart edge %0d: got %b want %b", k, got, exp);
      else begin passed++; $display("mid_restart edge %0d: e=%b mudou=%b", k, got.e, got.mudou); end
      if (got.e[1] && rise == 0) rise = k;
      pulses += int'(got.mudou);
    end
    total++;
    if (rise !== 6 || pulses !== 1)
      $display("FAIL mid_restart_timing: rise edge %0d pulses %0d, need 6 and 1", rise, pulses);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_release();
    test_simultaneous();
    test_bounce();
    test_walk();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
